// File: rtl/packet_round_robin_arbiter_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
// Provides the FSM state type and width / modulo helper functions.
package packet_round_robin_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_width(input int m);
      return (m > 0) ? $clog2(m + 1) : 1;
   endfunction

   // (a + b) mod n for small non-negative operands, exact for any n
   function automatic int mod_add(
      input int a,
      input int b,
      input int n
   );
      int s;
      s = a + b;
      while (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/packet_round_robin_arbiter_sel.sv
// Rotating priority select: first request at or after pointer, wrapping.
// Ports: requests, pointer in; one-hot grant, index, any out.
module rotating_priority_select
   import packet_round_robin_arbiter_pkg::*;
#(
   parameter int SIZE = 4,
   localparam int IW = idx_width(SIZE)
) (
   input  logic [SIZE-1:0] requests,
   input  logic [IW-1:0]   pointer,
   output logic [SIZE-1:0] grant,
   output logic [IW-1:0]   index,
   output logic            any
);

   logic [2*SIZE-1:0] dbl;

   // Doubling the vector lets a plain shift act as a rotate,
   // so bit k of the low half is channel (pointer + k) mod SIZE.
   assign dbl = {requests, requests} >> pointer;

   always_comb begin
      any   = 1'b0;
      index = '0;
      for (int k = 0; k < SIZE; k++) begin
         if (!any && dbl[k]) begin
            any   = 1'b1;
            index = IW'(mod_add(int'(pointer), k, SIZE));
         end
      end
   end

   assign grant = any ? (SIZE'(1) << index) : '0;

endmodule

// File: rtl/packet_round_robin_arbiter.sv
// Packet-locked round-robin arbiter sharing one valid/ready channel.
// Ports: clock, resetn, request_* (SIZE ch), output_*, grant, grant_index.
module packet_round_robin_arbiter
   import packet_round_robin_arbiter_pkg::*;
#(
   parameter int SIZE             = 4,
   parameter int WIDTH            = 8,
   parameter int MAX_PACKET_BEATS = 0,
   localparam int IW = idx_width(SIZE),
   localparam int BW = cnt_width(MAX_PACKET_BEATS)
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [SIZE-1:0]       request_valid,
   input  logic [SIZE-1:0]       request_last,
   input  logic [SIZE*WIDTH-1:0] request_data,
   output logic [SIZE-1:0]       request_ready,
   output logic                  output_valid,
   output logic                  output_last,
   output logic [WIDTH-1:0]      output_data,
   input  logic                  output_ready,
   output logic [SIZE-1:0]       grant,
   output logic [IW-1:0]         grant_index
);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_q, lock_d;
   logic [BW-1:0] beat_q, beat_d;

   logic [SIZE-1:0] sel_grant;
   logic [IW-1:0]   sel_idx;
   logic            sel_any;

   logic            locked;
   logic            active;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic            force_rel;
   logic            hs;

   rotating_priority_select #(
      .SIZE(SIZE)
   ) u_sel (
      .requests(request_valid),
      .pointer (ptr_q),
      .grant   (sel_grant),
      .index   (sel_idx),
      .any     (sel_any)
   );

   assign locked  = (state_q == ST_LOCKED);
   assign idx     = locked ? lock_q : sel_idx;
   assign active  = resetn & (locked | sel_any);
   assign idx_nxt = IW'(mod_add(int'(idx), 1, SIZE));

   assign force_rel = (MAX_PACKET_BEATS > 0) &&
      (beat_q == BW'(MAX_PACKET_BEATS - 1));

   assign output_valid = active & request_valid[idx];
   assign output_last  = output_valid &
      (request_last[idx] | force_rel);
   assign output_data  =
      request_data[int'(idx)*WIDTH +: WIDTH];
   assign hs = output_valid & output_ready;

   assign grant = active ? (SIZE'(1) << idx) : '0;
   assign grant_index = active ? idx : '0;
   assign request_ready =
      (active & output_ready) ? (SIZE'(1) << idx) : '0;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lock_d  = lock_q;
      beat_d  = beat_q;
      if (active) begin
         if (hs && output_last) begin
            state_d = ST_IDLE;
            ptr_d   = idx_nxt;
            beat_d  = '0;
         end else if (hs) begin
            state_d = ST_LOCKED;
            lock_d  = idx;
            beat_d  = beat_q + BW'(1);
         end else if (!locked) begin
            // lock an unaccepted winner so its valid stays owned
            state_d = ST_LOCKED;
            lock_d  = idx;
            beat_d  = '0;
         end
      end
      if (MAX_PACKET_BEATS == 0) beat_d = '0;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         lock_q  <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lock_q  <= lock_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_packet_round_robin_arbiter.sv
// Randomized + directed bench for packet_round_robin_arbiter.
// Two DUTs (MAX 0 and MAX 2) share stimulus; each has its own model.
module tb_packet_round_robin_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rstn;
   logic [N-1:0]   v, l;
   logic [N*W-1:0] d;
   logic           ordy;

   logic [1:0][N-1:0] rr, g;
   logic [1:0]        ov, ol;
   logic [1:0][W-1:0] od;
   logic [1:0][1:0]   gi;

   int nvec = 0;
   int nerr = 0;

   bit m_lock [2];
   int m_own  [2];
   int m_ptr  [2];
   int m_beat [2];
   int maxb   [2] = '{0, 2};

   int hs_log [$];
   logic [N-1:0] s_g  [2];
   logic [N-1:0] s_rr [2];
   logic [1:0]   s_gi [2];
   logic         s_ov [2];
   logic         s_ol [2];
   logic [W-1:0] s_od [2];

   always #5 clk = ~clk;

   packet_round_robin_arbiter #(
      .SIZE(N), .WIDTH(W), .MAX_PACKET_BEATS(0)
   ) dut0 (
      .clock(clk), .resetn(rstn),
      .request_valid(v), .request_last(l),
      .request_data(d), .request_ready(rr[0]),
      .output_valid(ov[0]), .output_last(ol[0]),
      .output_data(od[0]), .output_ready(ordy),
      .grant(g[0]), .grant_index(gi[0])
   );

   packet_round_robin_arbiter #(
      .SIZE(N), .WIDTH(W), .MAX_PACKET_BEATS(2)
   ) dut1 (
      .clock(clk), .resetn(rstn),
      .request_valid(v), .request_last(l),
      .request_data(d), .request_ready(rr[1]),
      .output_valid(ov[1]), .output_last(ol[1]),
      .output_data(od[1]), .output_ready(ordy),
      .grant(g[1]), .grant_index(gi[1])
   );

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h",
            tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         int o = 0;
         bit act = 0;
         bit eov, eol, hs;
         if (rstn && m_lock[u]) begin
            act = 1;
            o = m_own[u];
         end else if (rstn) begin
            for (int k = 0; k < N; k++) begin
               int c = (m_ptr[u] + k) % N;
               if (!act && v[c]) begin
                  act = 1;
                  o = c;
               end
            end
         end
         eov = act && v[o];
         eol = eov && (l[o] || (maxb[u] > 0 &&
            m_beat[u] == maxb[u] - 1));
         hs  = eov && ordy;
         s_g[u]  = g[u];
         s_rr[u] = rr[u];
         s_gi[u] = gi[u];
         s_ov[u] = ov[u];
         s_ol[u] = ol[u];
         s_od[u] = od[u];
         check($sformatf("u%0d grant", u), g[u],
            act ? (32'd1 << o) : 32'd0);
         check($sformatf("u%0d gidx", u), gi[u],
            act ? o : 0);
         check($sformatf("u%0d ready", u), rr[u],
            (act && ordy) ? (32'd1 << o) : 32'd0);
         check($sformatf("u%0d ovalid", u), ov[u], eov);
         check($sformatf("u%0d olast", u), ol[u], eol);
         if (eov)
            check($sformatf("u%0d odata", u), od[u],
               d[o*W +: W]);
         if (u == 0 && hs) hs_log.push_back(o);
         if (!rstn) begin
            m_lock[u] = 0;
            m_own[u]  = 0;
            m_ptr[u]  = 0;
            m_beat[u] = 0;
         end else if (act) begin
            if (hs && eol) begin
               m_lock[u] = 0;
               m_ptr[u]  = (o + 1) % N;
               m_beat[u] = 0;
            end else if (hs) begin
               m_lock[u] = 1;
               m_own[u]  = o;
               m_beat[u]++;
            end else if (!m_lock[u]) begin
               m_lock[u] = 1;
               m_own[u]  = o;
               m_beat[u] = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int ch, input int val);
      d[ch*W +: W] = W'(val);
   endtask

   initial begin
      int exp1 [5] = '{0, 1, 2, 3, 0};
      for (int u = 0; u < 2; u++) begin
         m_lock[u] = 0; m_own[u] = 0;
         m_ptr[u] = 0;  m_beat[u] = 0;
      end
      rstn = 0; v = '0; l = '0; d = '0; ordy = 0;
      @(posedge clk); #1;
      v = 4'b1111; ordy = 1;
      step();
      check("rst grant", s_g[0], 0);
      check("rst ovalid", s_ov[0], 0);
      step();
      rstn = 1; v = '0;
      step();

      // 1: all single-beat, full rotation
      hs_log.delete();
      v = 4'b1111; l = 4'b1111; ordy = 1;
      d = 32'h33221100;
      repeat (5) step();
      check("t1 count", hs_log.size(), 5);
      for (int i = 0; i < 5 && i < hs_log.size(); i++)
         check("t1 order", hs_log[i], exp1[i]);
      v = '0;
      step();

      // 2: ch2 3-beat packet, ch0 waiting
      v = 4'b0101; l = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         set_data(2, 8'hA0 + k);
         l[2] = (k == 2);
         step();
         check("t2 gidx", s_gi[0], 2);
         check("t2 data", s_od[0], 8'hA0 + k);
      end
      v = 4'b0001;
      step();
      check("t2 next", s_gi[0], 0);
      v = '0; l = '0;
      step();

      // 3: ch1 bubble while locked
      v = 4'b0010;
      step();
      v = 4'b0100;
      repeat (2) begin
         step();
         check("t3 ovalid", s_ov[0], 0);
         check("t3 grant", s_g[0], 4'b0010);
         check("t3 ready", s_rr[0] & 4'b1101, 0);
      end
      v = 4'b0010; l = 4'b0010;
      step();
      v = '0; l = '0;
      step();

      // 4: backpressure, no preemption
      ordy = 0; v = 4'b1000;
      step();
      v = 4'b1001;
      repeat (3) begin
         step();
         check("t4 gidx", s_gi[0], 3);
      end
      ordy = 1; l = 4'b1001;
      step();
      check("t4 accept", s_gi[0], 3);
      step();
      check("t4 next", s_gi[0], 0);
      v = '0; l = '0;
      step();

      // 5: forced release after 2 beats (dut1)
      rstn = 0;
      step();
      rstn = 1;
      v = 4'b0011; l = '0;
      step();
      check("t5 beat1 last", s_ol[1], 0);
      step();
      check("t5 beat2 last", s_ol[1], 1);
      step();
      check("t5 next", s_gi[1], 1);
      v = '0;
      step();

      // 6: reset mid-packet on ch2
      rstn = 0;
      step();
      rstn = 1; v = 4'b0100;
      repeat (2) step();
      rstn = 0; v = 4'b0101;
      step();
      check("t6 rst grant", s_g[0], 0);
      check("t6 rst ovalid", s_ov[0], 0);
      rstn = 1;
      step();
      check("t6 gidx0", s_gi[0], 0);
      check("t6 gidx1", s_gi[1], 0);
      v = '0;
      step();

      // random traffic
      repeat (3000) begin
         rstn = ($urandom_range(199) != 0);
         v    = N'($urandom);
         l    = N'($urandom) & N'($urandom);
         d    = $urandom;
         ordy = ($urandom_range(3) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==",
         nvec, nerr);
      $finish;
   end

endmodule
